// File: rtl/keymgr_pkg.sv
// rtl/keymgr_pkg.sv - keymgr sideload types and sizes shared by producer and consumers
package keymgr_pkg;

  localparam int Shares    = 2;
  localparam int KeyWidth  = 256;
  localparam int RandWidth = 32;
  localparam int NumWords  = KeyWidth / RandWidth;

  typedef struct packed {
    logic                            valid;
    logic [Shares-1:0][KeyWidth-1:0] key;
  } hw_key_req_t;

endpackage

// File: rtl/keymgr_sideload_key_rx.sv
// rtl/keymgr_sideload_key_rx.sv - captures sideload or software key per operation, holds it, wipes it with entropy
module keymgr_sideload_key_rx
  import keymgr_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sideload_en_i,
  input  hw_key_req_t                key_req_i,
  input  logic [Shares*KeyWidth-1:0] sw_key_i,
  input  logic                       sw_key_valid_i,
  input  logic                       op_req_i,
  output logic                       op_ack_o,
  input  logic                       done_i,
  input  logic                       wipe_i,
  input  logic [RandWidth-1:0]       entropy_i,
  output logic                       prng_en_o,
  output logic [Shares*KeyWidth-1:0] key_o,
  output logic                       key_valid_o,
  output logic                       err_o
);

  localparam int CntW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [CntW-1:0] LastWord = CntW'(NumWords - 1);

  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StActive   = 5'b00010,
    StClear    = 5'b00100,
    StErrClear = 5'b01000,
    StErr      = 5'b10000
  } state_e;

  state_e                          state_q, state_d;
  logic [Shares-1:0][KeyWidth-1:0] key_q, key_d;
  logic [CntW-1:0]                 cnt_q, cnt_d;
  logic                            src_sl_q, src_sl_d;
  logic                            ack_q, ack_d;
  logic                            err_q, err_d;
  logic                            src_valid;

  assign src_valid = sideload_en_i ? key_req_i.valid : sw_key_valid_i;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    cnt_d    = cnt_q;
    src_sl_d = src_sl_q;
    ack_d    = 1'b0;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (wipe_i) begin
          state_d = StErrClear;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (op_req_i && src_valid) begin
          if (sideload_en_i) begin
            key_d = key_req_i.key;
          end else begin
            key_d = sw_key_i;
          end
          src_sl_d = sideload_en_i;
          ack_d    = 1'b1;
          state_d  = StActive;
        end
      end

      StActive: begin
        // done outranks a simultaneous valid loss: the operation completed normally
        if (wipe_i) begin
          state_d = StErrClear;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else if (done_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (src_sl_q && !key_req_i.valid) begin
          state_d = StErrClear;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end

      StClear, StErrClear: begin
        if (wipe_i && (state_q == StClear)) begin
          state_d = StErrClear;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          for (int s = 0; s < Shares; s++) begin
            key_d[s][int'(cnt_q)*RandWidth +: RandWidth] = entropy_i;
          end
          if (cnt_q == LastWord) begin
            cnt_d   = '0;
            state_d = (state_q == StClear) ? StIdle : StErr;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StErr: begin
        state_d = StErr;
      end

      default: begin
        state_d = StErrClear;
        cnt_d   = '0;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      key_q    <= '0;
      cnt_q    <= '0;
      src_sl_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      src_sl_q <= src_sl_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign op_ack_o    = ack_q;
  assign key_valid_o = (state_q == StActive);
  assign err_o       = err_q;
  assign prng_en_o   = (state_q == StClear) || (state_q == StErrClear);
  assign key_o       = key_q;

endmodule
